// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared memory-interface widths, op codes and arbiter states
package mem_port_arbiter_pkg;

  localparam int IOSTATEWIDTH = 2;
  localparam int ADDRWIDTH    = 16;
  localparam int WORDWIDTH    = 32;

  localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd0;
  localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd1;
  localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Only RD and WT count as a request; every other code is treated as idle.
  function automatic logic is_req(input logic [IOSTATEWIDTH-1:0] rw);
    return (rw == RD) || (rw == WT);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - round-robin pick: first requester at or after ptr
module mem_port_arbiter_rr_pick #(
  parameter int NPORT = 4,
  parameter int PTRW  = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [PTRW-1:0]  ptr,
  output logic             any,
  output logic [PTRW-1:0]  idx
);

  logic [NPORT-1:0] rot;
  logic [PTRW-1:0]  off;
  logic [PTRW:0]    sum;
  logic             found;

  always_comb begin
    // Rotating the doubled vector puts port ptr at bit 0.
    rot   = NPORT'({req, req} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (!found && rot[i]) begin
        off   = PTRW'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTRW+1)'(NPORT)) begin
      sum = sum - (PTRW+1)'(NPORT);
    end
    idx = sum[PTRW-1:0];
    any = |req;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one memory port among NPORT cores
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int PTRW  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NPORT*IOSTATEWIDTH-1:0] reqRw,
  input  logic [NPORT*ADDRWIDTH-1:0]    reqAddr,
  input  logic [NPORT*WORDWIDTH-1:0]    reqData,
  output logic [NPORT-1:0]              reqRdEn,
  output logic [NPORT-1:0]              reqWtEn,
  output logic [WORDWIDTH-1:0]          reqDataOut,
  output logic [NPORT-1:0]              grant,
  output logic                          busy,
  output logic [IOSTATEWIDTH-1:0]       rwToMem,
  output logic [ADDRWIDTH-1:0]          addrToMem,
  output logic [WORDWIDTH-1:0]          dataToMem,
  input  logic                          rdEn,
  input  logic                          wtEn,
  input  logic [WORDWIDTH-1:0]          dataFromMem
);

  arb_state_t              state, state_n;
  logic [PTRW-1:0]         ptr, ptr_n, gidx, gidx_n, pick;
  logic [NPORT-1:0]        req, grant_n;
  logic                    any;
  logic [IOSTATEWIDTH-1:0] rw_n;
  logic [ADDRWIDTH-1:0]    addr_n;
  logic [WORDWIDTH-1:0]    data_n;
  logic                    done_rd, done_wt;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      req[i] = is_req(reqRw[i*IOSTATEWIDTH +: IOSTATEWIDTH]);
    end
  end

  mem_port_arbiter_rr_pick #(.NPORT(NPORT), .PTRW(PTRW)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (any),
    .idx (pick)
  );

  // Strobes only count in ISSUE and only when they match the latched op.
  assign done_rd    = (state == ARB_ISSUE) && (rwToMem == RD) && rdEn;
  assign done_wt    = (state == ARB_ISSUE) && (rwToMem == WT) && wtEn;
  assign reqRdEn    = done_rd ? grant : '0;
  assign reqWtEn    = done_wt ? grant : '0;
  assign reqDataOut = dataFromMem;
  assign busy       = (state != ARB_IDLE);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gidx_n  = gidx;
    grant_n = grant;
    rw_n    = rwToMem;
    addr_n  = addrToMem;
    data_n  = dataToMem;
    case (state)
      ARB_IDLE: begin
        if (any) begin
          gidx_n  = pick;
          grant_n = {{(NPORT-1){1'b0}}, 1'b1} << pick;
          rw_n    = reqRw[int'(pick)*IOSTATEWIDTH +: IOSTATEWIDTH];
          addr_n  = reqAddr[int'(pick)*ADDRWIDTH +: ADDRWIDTH];
          data_n  = reqData[int'(pick)*WORDWIDTH +: WORDWIDTH];
          state_n = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (done_rd || done_wt) begin
          rw_n    = IDEL;
          ptr_n   = (gidx == PTRW'(NPORT-1)) ? '0 : gidx + PTRW'(1);
          state_n = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        // Bubble cycle lets the owner drop its request before re-arbitration.
        grant_n = '0;
        state_n = ARB_IDLE;
      end
      default: begin
        grant_n = '0;
        rw_n    = IDEL;
        state_n = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      grant     <= '0;
      rwToMem   <= IDEL;
      addrToMem <= '0;
      dataToMem <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gidx      <= gidx_n;
      grant     <= grant_n;
      rwToMem   <= rw_n;
      addrToMem <= addr_n;
      dataToMem <= data_n;
    end
  end

endmodule
